sccb_cam_config: RTL

- SCCB (I2C-like, write-only) master that initialises the OV7670 camera after power-up. It must complete before the pixel-capture/frame-buffer path receives valid bytes.
- Walks a register table held in an external synchronous ROM. Emits one 3-phase write per entry: ID 0x42, register address, data.
- Supports a delay marker, for the post-soft-reset settle time, and an end marker.
- Sits beside the PLL in the camera top. Drives the GPIO_1 SIOC/SIOD pins through a top-level tri-state.

---
 rtl/sccb_cam_config.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_cam_config.sv
// SCCB write-only master that walks an OV7670 register table held in an
// external synchronous ROM. Each entry becomes one 3-phase write
// (DEV_ID, register address, data). 16'hFFF0 in the table inserts a settle
// delay and 16'hFFFF ends it. SIOC/SIOD are registered so the pins are
// glitch-free; they follow the sequencer state by one clock.
module sccb_cam_config #(
  parameter int unsigned QTR          = 125,
  parameter int unsigned DELAY_CYCLES = 500000,
  parameter int unsigned ADDR_W       = 8,
  parameter logic [7:0]  DEV_ID       = 8'h42
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);
  localparam logic [DW-1:0] DLAST = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [1:0]        quar_q, quar_d;
  logic [4:0]        bit_q, bit_d;
  logic [26:0]       shreg_q, shreg_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              fetch_q, fetch_d;
  logic              sioc_q, sioc_d;
  logic              sdo_q, sdo_d;
  logic              soe_q, soe_d;

  logic qend;
  logic top;
  logic dc_bit;

  // State and line registers; reset abandons any transfer without a STOP
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      qcnt_q  <= '0;
      quar_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dly_q   <= '0;
      fetch_q <= 1'b0;
      sioc_q  <= 1'b1;
      sdo_q   <= 1'b1;
      soe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      qcnt_q  <= qcnt_d;
      quar_q  <= quar_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dly_q   <= dly_d;
      fetch_q <= fetch_d;
      sioc_q  <= sioc_d;
      sdo_q   <= sdo_d;
      soe_q   <= soe_d;
    end
  end

  // Sequencer next state plus the line levels for the current quarter
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    qcnt_d  = '0;
    quar_d  = quar_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dly_d   = dly_q;
    fetch_d = fetch_q;
    sioc_d  = 1'b1;
    sdo_d   = 1'b1;
    soe_d   = 1'b0;
    qend    = (qcnt_q == QLAST);
    top     = (addr_q == '1);
    dc_bit  = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          fetch_d = 1'b0;
        end
      end

      S_FETCH: begin
        if (fetch_q) begin
          state_d = S_DECODE;
        end else begin
          fetch_d = 1'b1;
        end
      end

      S_DECODE: begin
        quar_d = '0;
        bit_d  = '0;
        if (rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          state_d = S_WAIT;
          dly_d   = '0;
        end else begin
          state_d = S_START;
          shreg_d = {DEV_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
        end
      end

      S_START: begin
        qcnt_d = qend ? '0 : qcnt_q + 1'b1;
        sioc_d = 1'b1;
        soe_d  = 1'b1;
        sdo_d  = 1'b0;
        if (qend) begin
          state_d = S_BITS;
        end
      end

      S_BITS: begin
        qcnt_d = qend ? '0 : qcnt_q + 1'b1;
        sioc_d = quar_q[1];
        soe_d  = ~dc_bit;
        sdo_d  = dc_bit ? 1'b1 : shreg_q[26];
        if (qend) begin
          if (quar_q == 2'd3) begin
            quar_d  = '0;
            shreg_d = {shreg_q[25:0], 1'b0};
            if (bit_q == 5'd26) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            quar_d = quar_q + 2'd1;
          end
        end
      end

      S_STOP: begin
        qcnt_d = qend ? '0 : qcnt_q + 1'b1;
        soe_d  = 1'b1;
        sioc_d = (quar_q != 2'd0);
        sdo_d  = (quar_q == 2'd2);
        if (qend) begin
          if (quar_q == 2'd2) begin
            state_d = S_GAP;
            quar_d  = '0;
          end else begin
            quar_d = quar_q + 2'd1;
          end
        end
      end

      S_GAP: begin
        qcnt_d = qend ? '0 : qcnt_q + 1'b1;
        if (qend) begin
          if (quar_q == 2'd3) begin
            quar_d = '0;
            // Top of the table: finish here instead of wrapping to entry 0
            if (top) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              fetch_d = 1'b0;
              state_d = S_FETCH;
            end
          end else begin
            quar_d = quar_q + 2'd1;
          end
        end
      end

      S_WAIT: begin
        if (dly_q == DLAST) begin
          if (top) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            fetch_d = 1'b0;
            state_d = S_FETCH;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_addr = addr_q;
  assign sioc     = sioc_q;
  assign siod_out = sdo_q;
  assign siod_oe  = soe_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule
